// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer:
// register offsets, CTRL bit positions, reset values and byte merging.
package timer_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESCALE = 3'd5
  } reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? din[8*i +: 8]
                          : old[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Down-counting prescaler: emits a one-cycle tick when the count
// is zero while enabled, then reloads from the programmed value.
import timer_pkg::*;

module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_reload,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_tick = i_en & w_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_zero) r_cnt <= i_reload;
      else        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Bus-attached 64-bit machine timer with compare interrupt,
// prescaler and atomic LO-then-HI read via a shadow register.
import timer_pkg::*;

module bus_timer #(
  parameter int XLEN       = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_timer_addr,
  input  logic            i_timer_write,
  input  logic            i_timer_read,
  input  logic [3:0]      i_timer_size,
  input  logic [XLEN-1:0] i_timer_din,
  output logic [XLEN-1:0] o_timer_dout,
  output logic            o_timer_irq
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_cmp;
  logic                  r_en;
  logic                  r_ien;
  logic [PRESCALE_W-1:0] r_pre;
  logic [31:0]           r_shadow;
  logic [XLEN-1:0]       r_dout;
  logic                  r_irq;

  logic [2:0]            w_idx;
  logic [7:0]            w_hit;
  logic                  w_wr;
  logic                  w_wr_lo;
  logic                  w_wr_hi;
  logic                  w_wr_clo;
  logic                  w_wr_chi;
  logic                  w_wr_ctrl;
  logic                  w_wr_pre;
  logic [1:0]            w_ctrl_new;
  logic [PRESCALE_W-1:0] w_pre_new;
  logic [31:0]           w_ctrl_rd;
  logic [31:0]           w_pre_rd;
  logic                  w_clr;
  logic                  w_tick;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_idx    = i_timer_addr[4:2];
  assign w_hit    = 8'b1 << w_idx;
  assign w_unused = &{1'b0, i_timer_addr[XLEN-1:5],
                      i_timer_addr[1:0]};

  // A write with no byte lanes is a no-op, including side effects.
  assign w_wr      = i_timer_write & (|i_timer_size);
  assign w_wr_lo   = w_wr & (w_idx == REG_MTIME_LO);
  assign w_wr_hi   = w_wr & (w_idx == REG_MTIME_HI);
  assign w_wr_clo  = w_wr & (w_idx == REG_CMP_LO);
  assign w_wr_chi  = w_wr & (w_idx == REG_CMP_HI);
  assign w_wr_ctrl = w_wr & (w_idx == REG_CTRL);
  assign w_wr_pre  = w_wr & (w_idx == REG_PRESCALE);

  assign w_ctrl_rd = {30'b0, r_ien, r_en};
  assign w_pre_rd  = 32'(r_pre);

  assign w_ctrl_new = 2'(be_merge(w_ctrl_rd,
                          i_timer_din, i_timer_size));
  assign w_pre_new  = PRESCALE_W'(be_merge(w_pre_rd,
                          i_timer_din, i_timer_size));

  assign w_clr = w_wr_pre |
                 (w_wr_ctrl & w_ctrl_new[CTRL_EN] & ~r_en);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_pre (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (r_en),
    .i_reload (r_pre),
    .i_clr    (w_clr),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_hit[REG_MTIME_LO]: w_rdata = r_mtime[31:0];
      w_hit[REG_MTIME_HI]: w_rdata = r_shadow;
      w_hit[REG_CMP_LO]:   w_rdata = r_cmp[31:0];
      w_hit[REG_CMP_HI]:   w_rdata = r_cmp[63:32];
      w_hit[REG_CTRL]:     w_rdata = w_ctrl_rd;
      w_hit[REG_PRESCALE]: w_rdata = w_pre_rd;
      default:             w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime  <= '0;
      r_cmp    <= CMP_RST;
      r_en     <= 1'b0;
      r_ien    <= 1'b0;
      r_pre    <= '0;
      r_shadow <= '0;
      r_dout   <= '0;
      r_irq    <= 1'b0;
    end else begin
      // Bus writes to either MTIME half suppress the increment.
      if (w_wr_lo)
        r_mtime[31:0] <= be_merge(r_mtime[31:0],
                           i_timer_din, i_timer_size);
      else if (w_wr_hi)
        r_mtime[63:32] <= be_merge(r_mtime[63:32],
                            i_timer_din, i_timer_size);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;

      if (w_wr_clo)
        r_cmp[31:0] <= be_merge(r_cmp[31:0],
                         i_timer_din, i_timer_size);
      if (w_wr_chi)
        r_cmp[63:32] <= be_merge(r_cmp[63:32],
                          i_timer_din, i_timer_size);

      if (w_wr_ctrl) begin
        r_en  <= w_ctrl_new[CTRL_EN];
        r_ien <= w_ctrl_new[CTRL_IRQ_EN];
      end
      if (w_wr_pre)
        r_pre <= w_pre_new;

      if (i_timer_read) begin
        r_dout <= w_rdata;
        if (w_idx == REG_MTIME_LO)
          r_shadow <= r_mtime[63:32];
      end

      r_irq <= r_ien & (r_mtime >= r_cmp);
    end
  end

  assign o_timer_dout = r_dout;
  assign o_timer_irq  = r_irq;

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter XLEN, default 32, bus data/address width; only 32 is supported.
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of the prescaler register and counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_timer_addr, input, XLEN, byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port i_timer_write, input, 1, write strobe, one access per cycle.
REQ-007 SHALL have port i_timer_read, input, 1, read strobe.
REQ-008 SHALL have port i_timer_size, input, 4, byte enables; bit n covers din[8n+7:8n].
REQ-009 SHALL have port i_timer_din, input, XLEN, write data.
REQ-010 SHALL have port o_timer_dout, output, XLEN, registered read data.
REQ-011 SHALL have port o_timer_irq, output, 1, level timer interrupt.

Function
REQ-012 SHALL act as a bus responder with the same read/write/size/din/dout protocol as the on-chip memory and UART slave ports; no wait states, no grant.
REQ-013 SHALL implement this register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL, 0x14 PRESCALE.
REQ-014 SHALL use CTRL bit0 EN (counting enable) and bit1 IRQ_EN; all other CTRL bits read 0.
REQ-015 SHALL return read data on o_timer_dout exactly one cycle after the read strobe; dout holds its value until the next read.
REQ-016 SHALL return 0 on reads of unmapped offsets (0x18-0x1C) and SHALL ignore writes to them.
REQ-017 SHALL apply writes at the clock edge, byte-masked by i_timer_size; size 4'b0000 writes nothing.
REQ-018 SHALL decrement a prescale counter while EN=1 and increment 64-bit MTIME by 1 when the counter is 0, then reload it from PRESCALE; PRESCALE=0 means increment every cycle.
REQ-019 SHALL clear the prescale counter to 0 on every write to PRESCALE and on a 0->1 transition of EN.
REQ-020 SHALL wrap MTIME from 0xFFFF_FFFF_FFFF_FFFF to 0 silently.
REQ-021 SHALL give a bus write to MTIME_LO/HI priority over an increment in the same cycle; the written half takes the bus value and the other half keeps its pre-write value (no carry).
REQ-022 SHALL, on a read of MTIME_LO, latch MTIME[63:32] into a shadow register in the same cycle; a read of MTIME_HI returns the shadow, giving an atomic 64-bit LO-then-HI read.
REQ-023 SHALL drive o_timer_irq, registered, to IRQ_EN && (MTIME >= CMP), unsigned 64-bit compare, one cycle after the condition changes.
REQ-024 SHALL keep irq asserted while the condition holds; it is cleared only by writing CMP above MTIME, clearing IRQ_EN, or writing MTIME.
REQ-025 SHALL, if read and write arrive together at one offset, return the pre-write value.

Reset
REQ-026 SHALL asynchronously reset on i_rst_n low: MTIME=0, CMP=0xFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescale counter=0, shadow=0, o_timer_dout=0, o_timer_irq=0.
REQ-027 SHALL abandon any in-flight read on reset mid-operation; no stale dout after release.

Structure
REQ-028 SHALL take register offsets, CTRL bit positions and CMP reset value from a shared package timer_pkg.
REQ-029 SHALL place the prescaler in sub-module timer_prescaler (inputs: enable, reload value, clear; output: one-cycle tick).

Verification
REQ-030 Reset, then read 0x08 and 0x0C -> both 0xFFFF_FFFF one cycle after the strobe; irq=0.
REQ-031 PRESCALE=3, CTRL=1, wait 40 cycles -> MTIME_LO = 10 (+-1 for setup cycle); ticks spaced exactly 4 cycles apart.
REQ-032 MTIME_LO=0xFFFF_FFFE, MTIME_HI=0, PRESCALE=0, EN=1; read LO then HI across the wrap -> HI from shadow is consistent with LO (0/1 pair never mismatched).
REQ-033 CMP=20, CTRL=3, PRESCALE=0 -> irq rises one cycle after MTIME reaches 20; writing CMP_LO=0x1000 drops irq next cycle.
REQ-034 Write MTIME_LO=0x55 with size 4'b0001 on a cycle that also ticks -> MTIME_LO=0x55 in byte 0, upper bytes keep pre-write value, no increment that cycle.
REQ-035 Assert i_rst_n low mid-read with irq active -> dout=0, irq=0 immediately; registers at reset values after release.
